// File: rtl/store_writeback_buffer.sv
// rtl/store_writeback_buffer.sv - coalescing eviction write-back queue with read forwarding
module store_writeback_buffer #(
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  store_en,
  input  logic [ADDR_WIDTH-1:0] store_addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wready,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic                  full,
  output logic                  overflow
);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_WIDTH-1:0]  head_q, tail_q;
  logic [PTR_WIDTH:0]    count_q;
  logic                  overflow_q, lookup_hit_q;
  logic [DATA_WIDTH-1:0] lookup_data_q;

  logic                  pop, append, drop, coal_hit;
  logic [PTR_WIDTH-1:0]  coal_idx, lk_idx;
  logic                  lk_hit_d;
  logic [DATA_WIDTH-1:0] lk_data_d;

  assign full        = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign mem_wen     = (count_q != '0);
  assign mem_waddr   = addr_q[head_q];
  assign mem_wdata   = data_q[head_q];
  assign overflow    = overflow_q;
  assign lookup_hit  = lookup_hit_q;
  assign lookup_data = lookup_data_q;

  always_comb begin
    pop      = mem_wen & mem_wready;
    coal_hit = 1'b0;
    coal_idx = '0;
    // The head may already be on the memory bus, so it is never rewritten.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == store_addr && PTR_WIDTH'(i) != head_q) begin
        coal_hit = 1'b1;
        coal_idx = PTR_WIDTH'(i);
      end
    end
    append = store_en & ~coal_hit & (~full | pop);
    drop   = store_en & ~coal_hit & full & ~pop;

    // Scan oldest to youngest so the last match wins; a same-cycle push is youngest of all.
    lk_hit_d  = 1'b0;
    lk_data_d = '0;
    lk_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PTR_WIDTH'(k);
      if (valid_q[lk_idx] && addr_q[lk_idx] == lookup_addr) begin
        lk_hit_d  = 1'b1;
        lk_data_d = data_q[lk_idx];
      end
    end
    if (store_en && store_addr == lookup_addr) begin
      lk_hit_d  = 1'b1;
      lk_data_d = store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      lookup_hit_q  <= 1'b0;
      lookup_data_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (store_en && coal_hit) data_q[coal_idx] <= store_data;
      // Placed after the pop clear so a full-queue append into the freed slot stays valid.
      if (append) begin
        addr_q[tail_q]  <= store_addr;
        data_q[tail_q]  <= store_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      case ({append, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
      lookup_hit_q  <= lk_hit_d;
      lookup_data_q <= lk_data_d;
    end
  end

endmodule
